// File: rtl/output_storage_streamer.sv
// Output storage for the PE-array psum path: a first-word-fall-through FIFO that
// streams a programmed number of beats over AXI4-Stream or feeds the head back to the first MAC.
module output_storage_streamer #(
   parameter int PSUM_W   = 32,
   parameter int AXI_M_DW = 32,
   parameter int DEPTH    = 16,
   parameter int CNT_W    = 16
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [PSUM_W-1:0]        psum_in,
   input  logic                     wr_en,
   input  logic                     start,
   input  logic [CNT_W-1:0]         num_outputs,
   input  logic                     fb_pop,
   output logic [PSUM_W-1:0]        fb_data,
   output logic                     fb_valid,
   output logic [AXI_M_DW-1:0]      M_AXIS_TDATA,
   output logic                     M_AXIS_TVALID,
   input  logic                     M_AXIS_TREADY,
   output logic                     M_AXIS_TLAST,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     done
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   generate
      if (AXI_M_DW != PSUM_W) begin : g_bad_width
         $error("output_storage_streamer: AXI_M_DW must equal PSUM_W");
      end
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("output_storage_streamer: DEPTH must be a power of two >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [CNT_W-1:0]  remaining_q, remaining_d;
   logic              overflow_q, overflow_d;
   logic [PSUM_W-1:0] mem [DEPTH];

   logic              push, pop, drop, handshake;
   logic [PSUM_W-1:0] head;

   assign head          = mem[rd_ptr_q[AW-1:0]];
   assign empty         = (count_q == '0);
   assign full          = (count_q == DEPTH_C);
   assign count         = count_q;
   assign overflow      = overflow_q;
   assign done          = (state_q == S_DONE);
   assign M_AXIS_TVALID = (state_q == S_STREAM) && !empty;
   assign M_AXIS_TLAST  = M_AXIS_TVALID && (remaining_q == CNT_W'(1));
   assign M_AXIS_TDATA  = head;
   assign fb_valid      = (state_q == S_IDLE) && !empty;
   assign fb_data       = head;

   // Pop sources are exclusive by state, so a plain OR is safe.
   assign handshake = M_AXIS_TVALID && M_AXIS_TREADY;
   assign pop       = handshake || (fb_pop && fb_valid);
   assign push      = wr_en && (!full || pop);
   assign drop      = wr_en && full && !pop;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      overflow_d  = overflow_q;
      wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
      rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
      count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (num_outputs != '0) begin
                  remaining_d = num_outputs;
                  overflow_d  = 1'b0;
                  state_d     = S_STREAM;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_STREAM: begin
            if (handshake) begin
               remaining_d = remaining_q - CNT_W'(1);
               if (remaining_q == CNT_W'(1)) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (drop) overflow_d = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         remaining_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         remaining_q <= remaining_d;
         overflow_q  <= overflow_d;
      end
   end

   // Storage carries no reset; stale entries are unreachable once pointers clear.
   always_ff @(posedge CLK) begin
      if (push && !RESET) mem[wr_ptr_q[AW-1:0]] <= psum_in;
   end

endmodule
